// File: rtl/axis_sigen_pkg.sv
// axis_sigen_pkg: shared widths, tuser field layout, port encodings, FSM states and strobe helper
package axis_sigen_pkg;

    localparam int TDATA_W = 256;
    localparam int TSTRB_W = 32;
    localparam int TUSER_W = 128;

    localparam int LEN_LSB = 0;
    localparam int SRC_LSB = 16;
    localparam int DST_LSB = 24;

    localparam logic [7:0] SRC_PORT = 8'h01;
    localparam logic [7:0] DST_P0   = 8'h01;
    localparam logic [7:0] DST_P1   = 8'h04;
    localparam logic [7:0] DST_P2   = 8'h10;
    localparam logic [7:0] DST_P3   = 8'h40;

    typedef enum logic [1:0] {SEND, GAP, DONE} state_t;

    // A remainder of zero means the last beat is completely full.
    function automatic logic [TSTRB_W-1:0] last_strb(input logic [15:0] len);
        return (len[4:0] == 5'd0) ? '1 : (32'h1 << len[4:0]) - 32'h1;
    endfunction

    function automatic logic [7:0] next_dst(input logic [7:0] dst);
        return (dst == DST_P0) ? DST_P1 :
               (dst == DST_P1) ? DST_P2 :
               (dst == DST_P2) ? DST_P3 : DST_P0;
    endfunction

endpackage

// File: rtl/axis_sigen.sv
// axis_sigen: deterministic fixed-length AXI4-Stream packet generator with NetFPGA tuser metadata
//   clk    in   sole clock
//   reset  in   synchronous active-high reset
//   tvalid out  AXIS valid
//   tready in   AXIS ready from the consumer
//   tdata  out  256-bit payload {8{seq, beat}}
//   tstrb  out  32-bit byte strobes
//   tuser  out  128-bit metadata, first beat only
//   tlast  out  final beat of a packet
module axis_sigen
    import axis_sigen_pkg::*;
#(
    parameter int PACKET_LEN  = 50,
    parameter int PKT_GAP     = 0,
    parameter int NUM_PACKETS = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               tvalid,
    input  logic               tready,
    output logic [TDATA_W-1:0] tdata,
    output logic [TSTRB_W-1:0] tstrb,
    output logic [TUSER_W-1:0] tuser,
    output logic               tlast
);

    localparam logic [15:0]        LEN16     = 16'(PACKET_LEN);
    localparam logic [15:0]        LAST_BEAT = 16'((PACKET_LEN + 31) / 32 - 1);
    localparam logic [31:0]        GAP_LAST  = 32'(PKT_GAP - 1);
    localparam logic [31:0]        NUM_PKTS  = 32'(NUM_PACKETS);
    localparam logic [TSTRB_W-1:0] LAST_STRB = last_strb(LEN16);

    state_t             state_q, state_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        beat_q, beat_d;
    logic [7:0]         dst_q, dst_d;
    logic [31:0]        gap_q, gap_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic               tvalid_q, tvalid_d;
    logic [TDATA_W-1:0] tdata_q, tdata_d;
    logic [TSTRB_W-1:0] tstrb_q, tstrb_d;
    logic [TUSER_W-1:0] tuser_q, tuser_d;
    logic               tlast_q, tlast_d;
    logic               fire;

    assign fire = tvalid_q && tready;

    // Outputs are derived from the next-state counters so that every
    // output is registered and a stall simply recomputes identical values.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        beat_d    = beat_q;
        dst_d     = dst_q;
        gap_d     = gap_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            SEND: begin
                if (fire && beat_q == LAST_BEAT) begin
                    seq_d     = seq_q + 16'd1;
                    beat_d    = '0;
                    dst_d     = next_dst(dst_q);
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    gap_d     = '0;
                    if (NUM_PACKETS != 0 && pkt_cnt_d == NUM_PKTS)
                        state_d = DONE;
                    else if (PKT_GAP > 0)
                        state_d = GAP;
                end else if (fire) begin
                    beat_d = beat_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = SEND;
                else
                    gap_d = gap_q + 32'd1;
            end
            default: ;
        endcase
        tvalid_d = state_d == SEND;
        tdata_d  = tvalid_d ? {8{seq_d, beat_d}} : '0;
        tstrb_d  = tvalid_d ? ((beat_d == LAST_BEAT) ? LAST_STRB : '1) : '0;
        tlast_d  = tvalid_d && beat_d == LAST_BEAT;
        tuser_d  = '0;
        if (tvalid_d && beat_d == 16'd0) begin
            tuser_d[LEN_LSB +: 16] = LEN16;
            tuser_d[SRC_LSB +: 8]  = SRC_PORT;
            tuser_d[DST_LSB +: 8]  = dst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEND;
            seq_q     <= '0;
            beat_q    <= '0;
            dst_q     <= DST_P0;
            gap_q     <= '0;
            pkt_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tstrb_q   <= '0;
            tuser_q   <= '0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            beat_q    <= beat_d;
            dst_q     <= dst_d;
            gap_q     <= gap_d;
            pkt_cnt_q <= pkt_cnt_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tstrb_q   <= tstrb_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tstrb  = tstrb_q;
    assign tuser  = tuser_q;
    assign tlast  = tlast_q;

endmodule

// File: tb/tb_axis_sigen.sv
// tb_axis_sigen: randomized-backpressure bench for four axis_sigen configurations against a packet-level model
module tb_axis_sigen;

    function automatic int len_of(int g);
        return (g == 0) ? 50 : (g == 1) ? 1 : (g == 2) ? 64 : 50;
    endfunction

    function automatic int gap_of(int g);
        return (g == 2) ? 3 : 0;
    endfunction

    function automatic int num_of(int g);
        return (g == 3) ? 2 : 0;
    endfunction

    function automatic logic [7:0] dst_tab(int i);
        return (i == 0) ? 8'h01 : (i == 1) ? 8'h04 : (i == 2) ? 8'h10 : 8'h40;
    endfunction

    function automatic logic [255:0] exp_data(int p, int b);
        logic [31:0] w;
        w = {p[15:0], b[15:0]};
        return {8{w}};
    endfunction

    function automatic logic [31:0] exp_strb(int len, int b);
        logic [31:0] s;
        for (int i = 0; i < 32; i++) s[i] = (b * 32 + i) < len;
        return s;
    endfunction

    function automatic logic [127:0] exp_user(int len, int p, int b);
        logic [127:0] u;
        u = '0;
        if (b == 0) begin
            u[15:0]  = len[15:0];
            u[23:16] = 8'h01;
            u[31:24] = dst_tab(p % 4);
        end
        return u;
    endfunction

    function automatic string t(int g, string s);
        return $sformatf("u%0d_%s", g, s);
    endfunction

    logic         clk;
    logic         rst;
    logic         tv[4];
    logic         tr[4];
    logic         tl[4];
    logic [255:0] td[4];
    logic [31:0]  ts[4];
    logic [127:0] tu[4];

    int checks;
    int errors;

    int           m_pkt[4];
    int           m_beat[4];
    int           pkts[4];
    int           xfers[4];
    int           idle[4];
    bit           saw_end[4];
    bit           stall_q[4];
    bit           rst_prev[4];
    logic [417:0] held[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axis_sigen #(
            .PACKET_LEN (len_of(g)),
            .PKT_GAP    (gap_of(g)),
            .NUM_PACKETS(num_of(g))
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .tvalid(tv[g]),
            .tready(tr[g]),
            .tdata (td[g]),
            .tstrb (ts[g]),
            .tuser (tu[g]),
            .tlast (tl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int g);
        m_pkt[g]   = 0;
        m_beat[g]  = 0;
        pkts[g]    = 0;
        xfers[g]   = 0;
        idle[g]    = 0;
        saw_end[g] = 0;
        stall_q[g] = 0;
    endtask

    task automatic step(input int g);
        int   nb;
        logic exp_tv;
        nb = (len_of(g) + 31) / 32;
        if (stall_q[g])
            chk(t(g, "hold"), {tv[g], tl[g], td[g], ts[g], tu[g]}, held[g]);
        if (num_of(g) != 0 && pkts[g] == num_of(g)) begin
            exp_tv = 1'b0;
        end else if (saw_end[g] && idle[g] < gap_of(g)) begin
            exp_tv = 1'b0;
            idle[g]++;
        end else begin
            exp_tv = 1'b1;
            saw_end[g] = 0;
        end
        chk(t(g, "tvalid"), tv[g], exp_tv);
        if (tv[g] && tr[g]) begin
            chk(t(g, "tdata"), td[g], exp_data(m_pkt[g], m_beat[g]));
            chk(t(g, "tstrb"), ts[g], exp_strb(len_of(g), m_beat[g]));
            chk(t(g, "tuser"), tu[g], exp_user(len_of(g), m_pkt[g], m_beat[g]));
            chk(t(g, "tlast"), tl[g], m_beat[g] == nb - 1);
            xfers[g]++;
            if (m_beat[g] == nb - 1) begin
                m_beat[g]  = 0;
                m_pkt[g]++;
                pkts[g]++;
                saw_end[g] = 1;
                idle[g]    = 0;
            end else begin
                m_beat[g]++;
            end
        end
        stall_q[g] = tv[g] && !tr[g];
        held[g]    = {tv[g], tl[g], td[g], ts[g], tu[g]};
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rst_prev[g])
                chk(t(g, "reset_zero"), {tv[g], tl[g], td[g], ts[g], tu[g]}, '0);
            if (rst) begin
                model_reset(g);
                rst_prev[g] = 1;
            end else if (rst_prev[g]) begin
                rst_prev[g] = 0;
            end else begin
                step(g);
            end
        end
    end

    initial begin
        bit found;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) tr[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int g = 0; g < 4; g++) tr[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("a_b0_data", td[0], {8{32'h0000_0000}});
        chk("a_b0_strb", ts[0], 32'hFFFF_FFFF);
        chk("a_b0_user", tu[0][31:0], 32'h0101_0032);
        chk("a_b0_last", tl[0], 1'b0);
        chk("b_b0_strb", ts[1], 32'h1);
        chk("b_b0_last", tl[1], 1'b1);
        @(negedge clk);
        #1;
        chk("a_b1_data", td[0], {8{32'h0000_0001}});
        chk("a_b1_strb", ts[0], 32'h0003_FFFF);
        chk("a_b1_user", tu[0], 128'h0);
        chk("a_b1_last", tl[0], 1'b1);
        @(negedge clk);
        #1;
        chk("a_p1_valid", tv[0], 1'b1);
        chk("a_p1_data", td[0], {8{32'h0001_0000}});
        chk("a_p1_dst", tu[0][31:24], 8'h04);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_pkt[0] == 3 && m_beat[0] == 1) found = 1;
        end
        chk("wait_p3b1", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out", {tv[0], tl[0], td[0], tu[0]}, '0);
        @(negedge clk);
        #1;
        chk("restart_valid", tv[0], 1'b1);
        chk("restart_data", td[0], {8{32'h0000_0000}});
        chk("restart_dst", tu[0][31:24], 8'h01);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_beat[0] == 1) found = 1;
        end
        chk("wait_mid", found, 1'b1);
        tr[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 tr[0] = 1'b1;
        repeat (1500) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) tr[g] = $urandom_range(0, 3) != 0;
        end
        for (int g = 0; g < 4; g++) tr[g] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        chk("d_xfers", xfers[3], 4);
        chk("d_idle", tv[3], 1'b0);
        chk("c_progress", pkts[2] > 20, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
